// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Purpose:
//   Stall, bubble and flush sequencer for the 5-stage core (IF/ID/EX/MA/WB).
//   - Detects RAW hazards between the ID-stage sources and the EX/MA
//     destinations. With forwarding enabled, only load-use hazards stall.
//   - Freezes the whole pipeline while the data SRAM has not completed an
//     access.
//   - Keeps flush_if_id high for FLUSH_CYCLES unfrozen cycles per taken
//     branch.
//   All control outputs are combinational from the registered state and the
//   current inputs. Priority: memory wait > flush > hazard.
//
// Parameters:
//   REG_W        register-address width
//   FLUSH_CYCLES cycles flush_if_id stays high per taken branch (>= 1)
//   HAZ_MAX      consecutive bubble cycles before haz_timeout sets
//   CNT_W        width of the optional performance counters
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   forward_en            1 = forwarding active, only load-use stalls
//   id_valid              ID stage holds a real instruction
//   id_src1, id_src2      ID source registers
//   id_two_src            ID instruction reads id_src2
//   ex_dest, ex_wb_en     EX destination and write-back enable
//   ex_mem_r_en           EX instruction is a load
//   ma_dest, ma_wb_en     MA destination and write-back enable
//   branch_taken          EX resolved a taken branch
//   mem_req, mem_ready    SRAM access request / completion
//   freeze_pc             hold PC and IF/ID
//   bubble_ex             load NOP into ID/EX
//   flush_if_id           clear IF/ID and ID/EX
//   freeze_all            hold every pipeline register
//   haz_timeout           sticky: a hazard stall lasted HAZ_MAX cycles
//   state                 00 RUN, 01 MEM_WAIT, 10 FLUSH
//
// Configuration:
//   HAZARD_PERF_CNT_EN    when defined, adds saturating counters
//                         stall_cnt (bubble_ex cycles), memwait_cnt
//                         (freeze_all cycles) and flush_cnt (taken branches).
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int HAZ_MAX      = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [REG_W-1:0] ma_dest,
  input  logic             ma_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             haz_timeout,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_FLUSH    = 2'b10
  } state_t;

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int HCNT_W = $clog2(HAZ_MAX + 1);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HAZ_SAT    = HCNT_W'(HAZ_MAX);
  localparam logic [HCNT_W-1:0] HAZ_LAST   = HCNT_W'(HAZ_MAX - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FCNT_W-1:0]   r_flush_cnt;
  logic [FCNT_W-1:0]   w_flush_cnt_nxt;
  logic [HCNT_W-1:0]   r_haz_cnt;
  logic                r_haz_timeout;

  logic w_mem_stall;
  logic w_ex_m1, w_ex_m2, w_ma_m1, w_ma_m2;
  logic w_ex_match, w_ma_match;
  logic w_hazard;
  logic w_freeze_pc, w_bubble_ex, w_flush_if_id, w_freeze_all;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_mem_stall = mem_req & ~mem_ready;

  assign w_ex_m1 = (id_src1 == ex_dest) & ex_wb_en;
  assign w_ex_m2 = id_two_src & (id_src2 == ex_dest) & ex_wb_en;
  assign w_ma_m1 = (id_src1 == ma_dest) & ma_wb_en;
  assign w_ma_m2 = id_two_src & (id_src2 == ma_dest) & ma_wb_en;

  assign w_ex_match = w_ex_m1 | w_ex_m2;
  assign w_ma_match = w_ma_m1 | w_ma_m2;

  // With forwarding, only a load in EX cannot be bypassed in time.
  assign w_hazard = id_valid &
                    (forward_en ? (ex_mem_r_en & w_ex_match)
                                : (w_ex_match | w_ma_match));

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and raw control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_freeze_pc     = 1'b0;
    w_bubble_ex     = 1'b0;
    w_flush_if_id   = 1'b0;
    w_freeze_all    = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_freeze_all = 1'b1;
          w_state_nxt  = S_MEM_WAIT;
        end else if (branch_taken) begin
          w_flush_if_id = 1'b1;
          // A single-cycle flush is fully served in this cycle.
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (w_hazard) begin
          w_freeze_pc = 1'b1;
          w_bubble_ex = 1'b1;
        end
      end

      // Branch and hazard requests are held by the frozen pipeline and are
      // picked up again once back in RUN.
      S_MEM_WAIT: begin
        w_freeze_all = ~mem_ready;
        if (mem_ready) begin
          w_state_nxt = S_RUN;
        end
      end

      // flush_if_id stays high through a memory stall, so the stall simply
      // stretches the flush window while the counter holds.
      S_FLUSH: begin
        w_flush_if_id = 1'b1;
        if (w_mem_stall) begin
          w_freeze_all = 1'b1;
        end else if (branch_taken) begin
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (r_flush_cnt == FCNT_W'(1)) begin
          w_flush_cnt_nxt = '0;
          w_state_nxt     = S_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
        end
      end

      default: begin
        w_state_nxt     = S_RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are forced low the moment rst_n drops, not at the next edge.
  assign freeze_pc   = rst_n & w_freeze_pc;
  assign bubble_ex   = rst_n & w_bubble_ex;
  assign flush_if_id = rst_n & w_flush_if_id;
  assign freeze_all  = rst_n & w_freeze_all;
  assign haz_timeout = r_haz_timeout;
  assign state       = r_state;

  // ---------------------------------------------------------------------------
  // Hazard watchdog: consecutive bubble cycles, sticky timeout
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_haz_cnt     <= '0;
      r_haz_timeout <= 1'b0;
    end else if (w_bubble_ex) begin
      if (r_haz_cnt != HAZ_SAT) begin
        r_haz_cnt <= r_haz_cnt + HCNT_W'(1);
      end
      // This bubble is the HAZ_MAX-th in a row.
      if (r_haz_cnt >= HAZ_LAST) begin
        r_haz_timeout <= 1'b1;
      end
    end else begin
      r_haz_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_memwait_cnt;
  logic [CNT_W-1:0] r_flush_cnt_perf;
  logic             w_branch_acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A branch is accepted when it is acted on, not while it waits behind a
  // frozen pipeline.
  assign w_branch_acc = branch_taken & ~w_mem_stall &
                        ((r_state == S_RUN) | (r_state == S_FLUSH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt      <= '0;
      r_memwait_cnt    <= '0;
      r_flush_cnt_perf <= '0;
    end else begin
      if (w_bubble_ex)  r_stall_cnt      <= sat_inc(r_stall_cnt);
      if (w_freeze_all) r_memwait_cnt    <= sat_inc(r_memwait_cnt);
      if (w_branch_acc) r_flush_cnt_perf <= sat_inc(r_flush_cnt_perf);
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign memwait_cnt = r_memwait_cnt;
  assign flush_cnt   = r_flush_cnt_perf;
`else
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int REG_W = 4;
  localparam int FC    = 3;
  localparam int HM    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fe, idv, two, exw, exl, maw, br, mrq, mrd;
  logic [REG_W-1:0] s1, s2, exd, mad;

  logic             freeze_pc, bubble_ex, flush_if_id, freeze_all, haz_timeout;
  logic [1:0]       state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, memwait_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .REG_W(REG_W), .FLUSH_CYCLES(FC), .HAZ_MAX(HM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .forward_en(fe), .id_valid(idv),
    .id_src1(s1), .id_src2(s2), .id_two_src(two),
    .ex_dest(exd), .ex_wb_en(exw), .ex_mem_r_en(exl),
    .ma_dest(mad), .ma_wb_en(maw), .branch_taken(br),
    .mem_req(mrq), .mem_ready(mrd),
    .freeze_pc(freeze_pc), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .freeze_all(freeze_all), .haz_timeout(haz_timeout), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .memwait_cnt(memwait_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Reference state: mode 0 RUN, 1 MEM_WAIT, 2 FLUSH; flush cycles served so
  // far for the current branch; length of the current run of bubbles.
  int m_mode   = 0;
  int m_served = 0;
  int m_hrun   = 0;
  bit m_to     = 1'b0;

  function automatic bit ref_hazard();
    bit ex_hit, ma_hit;
    ex_hit = exw && (s1 == exd || (two && s2 == exd));
    ma_hit = maw && (s1 == mad || (two && s2 == mad));
    if (!idv) return 1'b0;
    return fe ? (exl && ex_hit) : (ex_hit || ma_hit);
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, want %b ({fpc,bub,fl,fa,to,st})",
               name, $time, got, want);
    end
  endtask

  task automatic idle();
    fe = 0; idv = 0; two = 0; exw = 0; exl = 0; maw = 0; br = 0; mrq = 0; mrd = 0;
    s1 = '0; s2 = '0; exd = '0; mad = '0;
  endtask

  // Called at a falling edge after inputs are set; checks, then advances one cycle.
  task automatic step(input logic [6:0] lit, input bit use_lit, input string name);
    logic [6:0] exp_v, got_v;
    bit stall, fp, bx, fl, fa;
    #1;
    n_vec++;
    stall = mrq && !mrd;
    fp = 0; bx = 0; fl = 0; fa = 0;
    if (!rst_n) begin
      m_mode = 0; m_served = 0; m_hrun = 0; m_to = 0;
      exp_v = 7'b0;
    end else begin
      case (m_mode)
        0: begin
          if (stall) fa = 1;
          else if (br) fl = 1;
          else if (ref_hazard()) begin fp = 1; bx = 1; end
        end
        1: fa = !mrd;
        default: begin fl = 1; fa = stall; end
      endcase
      exp_v = {fp, bx, fl, fa, m_to, 2'(m_mode)};
      if (bx) begin
        m_hrun++;
        if (m_hrun >= HM) m_to = 1;
      end else begin
        m_hrun = 0;
      end
      case (m_mode)
        0: begin
          if (stall) m_mode = 1;
          else if (br && FC > 1) begin m_mode = 2; m_served = 1; end
        end
        1: if (mrd) m_mode = 0;
        default: begin
          if (!stall) begin
            if (br) m_served = 1;
            else begin
              m_served++;
              if (m_served == FC) m_mode = 0;
            end
          end
        end
      endcase
    end
    got_v = {freeze_pc, bubble_ex, flush_if_id, freeze_all, haz_timeout, state};
    check("model", got_v, exp_v);
    if (use_lit) begin
      check(name, got_v, lit);
      check({name, "_ref"}, exp_v, lit);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    step(7'b0000000, 1, "reset");
    rst_n = 1;
    step(7'b0000000, 1, "post_reset_idle");

    fe = 0; idv = 1; s1 = 4'd3; exd = 4'd3; exw = 1;
    step(7'b1100000, 1, "raw_nofwd");
    fe = 1;
    step(7'b0000000, 1, "fwd_noload");
    exl = 1;
    step(7'b1100000, 1, "load_use");
    idle();
    step(7'b0000000, 1, "load_use_done");

    mrq = 1; br = 1;
    step(7'b0001000, 1, "mw_enter");
    step(7'b0001001, 1, "mw_hold1");
    step(7'b0001001, 1, "mw_hold2");
    mrd = 1;
    step(7'b0000001, 1, "mw_exit");
    mrq = 0; mrd = 0;
    step(7'b0010000, 1, "br_after_mw");
    br = 0;
    step(7'b0010010, 1, "flush2");
    step(7'b0010010, 1, "flush3");
    step(7'b0000000, 1, "flush_done");

    br = 1;
    step(7'b0010000, 1, "fl_branch");
    br = 0;
    step(7'b0010010, 1, "fl_2");
    mrq = 1;
    step(7'b0011010, 1, "fl_stall1");
    step(7'b0011010, 1, "fl_stall2");
    mrq = 0;
    step(7'b0010010, 1, "fl_3");
    step(7'b0000000, 1, "fl_done");

    fe = 0; idv = 1; s1 = 4'd3; exd = 4'd3; exw = 1;
    for (int i = 0; i < HM; i++) step(7'b1100000, 1, "haz_hold");
    idle();
    step(7'b0000100, 1, "timeout_set");
    step(7'b0000100, 1, "timeout_sticky");

    mrq = 1;
    step(7'b0001100, 1, "mw2_enter");
    step(7'b0001101, 1, "mw2_hold");
    rst_n = 0;
    step(7'b0000000, 1, "rst_in_mw");
    step(7'b0000000, 1, "rst_held");
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if (stall_cnt !== '0 || memwait_cnt !== '0 || flush_cnt !== '0) begin
      n_err++;
      $display("FAIL perf_cnt_reset: got %0d/%0d/%0d, want 0/0/0",
               stall_cnt, memwait_cnt, flush_cnt);
    end
`endif
    rst_n = 1; mrq = 0;
    step(7'b0000000, 1, "rst_released");

    for (int i = 0; i < 3000; i++) begin
      fe  = 1'($urandom_range(0, 1));
      idv = ($urandom_range(0, 3) != 0);
      two = 1'($urandom_range(0, 1));
      s1  = 4'($urandom_range(0, 3));
      s2  = 4'($urandom_range(0, 3));
      exd = 4'($urandom_range(0, 3));
      mad = 4'($urandom_range(0, 3));
      exw = 1'($urandom_range(0, 1));
      exl = 1'($urandom_range(0, 1));
      maw = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 7) == 0);
      mrq = ($urandom_range(0, 3) == 0);
      mrd = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 299) != 0);
      step(7'b0000000, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
